// File: rtl/pcileech_sysctl_pkg.sv
// Shared types for the Enigma X1 system control sequencer.
// Holds the sequencer state encoding and a small elaboration-time helper.
package pcileech_sysctl_pkg;

    typedef enum logic [1:0] {
        S_POR      = 2'd0,
        S_RUN      = 2'd1,
        S_HOLD     = 2'd2,
        S_RELOADED = 2'd3
    } sysctl_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcileech_sysctl_if.sv
// Button inputs and reset/LED outputs of the system control sequencer.
// The master side is the sequencer itself; the slave side is the board and its consumers.
interface pcileech_sysctl_if;
    logic        user_sw1_n;
    logic        user_sw2_n;
    logic        rst_sys;
    logic        ft601_rst_n;
    logic        rst_cfg_reload;
    logic        led_invert;
    logic [63:0] uptime;

    modport master (
        input  user_sw1_n,
        input  user_sw2_n,
        output rst_sys,
        output ft601_rst_n,
        output rst_cfg_reload,
        output led_invert,
        output uptime
    );

    modport slave (
        output user_sw1_n,
        output user_sw2_n,
        input  rst_sys,
        input  ft601_rst_n,
        input  rst_cfg_reload,
        input  led_invert,
        input  uptime
    );
endinterface

// File: rtl/pcileech_sysctl_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for one active-low button.
// db is active high (pressed) and only follows the synchronized level after it has been stable long enough.
module pcileech_debounce #(
    parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic db
);
    localparam int unsigned CW = (PARAM_DEBOUNCE_CYCLES > 1) ? $clog2(PARAM_DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PARAM_DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            db      <= 1'b0;
        end else begin
            // stage p0/p1: metastability guard on the inverted (pressed = 1) level
            sync_p0 <= ~btn_n;
            sync_p1 <= sync_p0;
            // any return to the accepted level restarts the stability window
            if (sync_p1 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcileech_sysctl.sv
// System control sequencer: POR and button-driven system reset, FT601 reset,
// long-press configuration reload request and the power-on LED blink mask.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int unsigned PARAM_RST_CYCLES       = 64,
    parameter int unsigned PARAM_DEBOUNCE_CYCLES  = 1000000,
    parameter int unsigned PARAM_RELOAD_CYCLES    = 500000000,
    parameter int unsigned PARAM_BLINK_BIT        = 24,
    parameter int unsigned PARAM_BLINK_WINDOW_BIT = 27
) (
    input  logic              clk,
    input  logic              rst,
    pcileech_sysctl_if.master sys
);
    localparam int unsigned CNT_MAX = max_u(PARAM_RST_CYCLES, PARAM_RELOAD_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PARAM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOAD_LAST = CNT_W'(PARAM_RELOAD_CYCLES - 1);

    sysctl_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             sw1_db;
    logic             sw2_db;
    logic             blink;

    pcileech_debounce #(.PARAM_DEBOUNCE_CYCLES(PARAM_DEBOUNCE_CYCLES)) u_sw1 (
        .clk   (clk),
        .rst   (rst),
        .btn_n (sys.user_sw1_n),
        .db    (sw1_db)
    );

    pcileech_debounce #(.PARAM_DEBOUNCE_CYCLES(PARAM_DEBOUNCE_CYCLES)) u_sw2 (
        .clk   (clk),
        .rst   (rst),
        .btn_n (sys.user_sw2_n),
        .db    (sw2_db)
    );

    // blink only inside the early-uptime window, so the LED settles once the system has been up a while
    assign blink = sys.uptime[PARAM_BLINK_BIT] & ~(|sys.uptime[63:PARAM_BLINK_WINDOW_BIT]);

    assign sys.ft601_rst_n = ~sys.rst_sys;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_POR;
            cnt                <= '0;
            sys.rst_sys        <= 1'b1;
            sys.rst_cfg_reload <= 1'b0;
            sys.led_invert     <= 1'b0;
            sys.uptime         <= '0;
        end else begin
            sys.rst_cfg_reload <= 1'b0;
            sys.led_invert     <= sw1_db ^ blink;
            case (state)
                S_POR: begin
                    sys.rst_sys <= 1'b1;
                    sys.uptime  <= '0;
                    if (sw2_db) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else if (cnt == RST_LAST) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        sys.rst_sys <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (sw2_db) begin
                        state       <= S_HOLD;
                        cnt         <= '0;
                        sys.rst_sys <= 1'b1;
                        sys.uptime  <= '0;
                    end else begin
                        sys.rst_sys <= 1'b0;
                        sys.uptime  <= sys.uptime + 64'd1;
                    end
                end
                S_HOLD: begin
                    sys.rst_sys <= 1'b1;
                    sys.uptime  <= '0;
                    // a release always wins over the reload threshold
                    if (!sw2_db) begin
                        state <= S_POR;
                        cnt   <= '0;
                    end else if (cnt == RELOAD_LAST) begin
                        state              <= S_RELOADED;
                        cnt                <= '0;
                        sys.rst_cfg_reload <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELOADED: begin
                    sys.rst_sys <= 1'b1;
                    sys.uptime  <= '0;
                    if (!sw2_db) begin
                        state <= S_POR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_POR;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcileech_sysctl.sv
// Self-checking bench for pcileech_sysctl with the small test-plan parameters.
module tb_pcileech_sysctl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pcileech_sysctl_if sif ();

    pcileech_sysctl #(
        .PARAM_RST_CYCLES       (8),
        .PARAM_DEBOUNCE_CYCLES  (4),
        .PARAM_RELOAD_CYCLES    (100),
        .PARAM_BLINK_BIT        (3),
        .PARAM_BLINK_WINDOW_BIT (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sys (sif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int reload_seen = 0;

    always @(negedge clk) if (sif.rst_cfg_reload === 1'b1) reload_seen++;

    typedef struct {
        bit          sw1_n;
        bit          sw2_n;
        bit          exp_rst_sys;
        bit          exp_ft601_rst_n;
        logic [63:0] exp_uptime;
    } vec_t;

    typedef struct {
        bit          exp_rst_sys;
        bit          exp_ft601_rst_n;
        logic [63:0] exp_uptime;
        bit          exp_led;
    } sb_t;

    vec_t tbl [12];
    sb_t  sb_q [$];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // expected uptime n edges after rst release with buttons idle
    function automatic logic [63:0] exp_up(input int n);
        return (n >= 9) ? 64'(n - 8) : 64'd0;
    endfunction

    function automatic bit blink_of(input logic [63:0] u);
        return u[3] && ((u >> 6) == 64'd0);
    endfunction

    function automatic bit exp_led(input int n, input bit sw1_held);
        bit inv;
        bit blk;
        inv = sw1_held && (n >= 7);
        blk = (n >= 2) ? blink_of(exp_up(n - 1)) : 1'b0;
        return inv ^ blk;
    endfunction

    task automatic por_start(input bit sw1_n);
        rst = 1'b1;
        sif.user_sw1_n = sw1_n;
        sif.user_sw2_n = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic run_to_run();
        por_start(1'b1);
        repeat (10) step();
    endtask

    task automatic release_checks(input string tag);
        for (int r = 1; r <= 16; r++) begin
            step();
            if (r == 14) chk({tag, "_rel_hold14"}, 64'(sif.rst_sys), 64'd1);
            if (r == 15) begin
                chk({tag, "_rel_run15"}, 64'(sif.rst_sys), 64'd0);
                chk({tag, "_rel_up15"}, sif.uptime, 64'd0);
            end
            if (r == 16) chk({tag, "_rel_up16"}, sif.uptime, 64'd1);
        end
    endtask

    task automatic blink_run(input bit sw1_held);
        sb_t e;
        sb_t g;
        por_start(sw1_held ? 1'b0 : 1'b1);
        for (int n = 1; n <= 80; n++) begin
            e.exp_rst_sys     = (n < 8);
            e.exp_ft601_rst_n = (n >= 8);
            e.exp_uptime      = exp_up(n);
            e.exp_led         = exp_led(n, sw1_held);
            sb_q.push_back(e);
            step();
            g = sb_q.pop_front();
            chk(sw1_held ? "blink_inv_led" : "blink_led", 64'(sif.led_invert), 64'(g.exp_led));
        end
        chk("blink_uptime80", sif.uptime, exp_up(80));
        sif.user_sw1_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int hi_cnt;
        sb_t g;

        for (int i = 0; i < 12; i++) begin
            tbl[i].sw1_n           = 1'b1;
            tbl[i].sw2_n           = 1'b1;
            tbl[i].exp_rst_sys     = ((i + 1) < 8);
            tbl[i].exp_ft601_rst_n = ((i + 1) >= 8);
            tbl[i].exp_uptime      = exp_up(i + 1);
        end

        sif.user_sw1_n = 1'b1;
        sif.user_sw2_n = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        chk("reset_rst_sys", 64'(sif.rst_sys), 64'd1);
        chk("reset_ft601", 64'(sif.ft601_rst_n), 64'd0);
        chk("reset_reload", 64'(sif.rst_cfg_reload), 64'd0);
        chk("reset_led", 64'(sif.led_invert), 64'd0);
        chk("reset_uptime", sif.uptime, 64'd0);

        // POR release, table-driven through the scoreboard
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sif.user_sw1_n = tbl[i].sw1_n;
            sif.user_sw2_n = tbl[i].sw2_n;
            sb_q.push_back('{tbl[i].exp_rst_sys, tbl[i].exp_ft601_rst_n, tbl[i].exp_uptime, 1'b0});
            step();
            g = sb_q.pop_front();
            chk("por_rst_sys", 64'(sif.rst_sys), 64'(g.exp_rst_sys));
            chk("por_ft601", 64'(sif.ft601_rst_n), 64'(g.exp_ft601_rst_n));
            chk("por_uptime", sif.uptime, g.exp_uptime);
        end

        blink_run(1'b0);
        blink_run(1'b1);

        // short SW2 press
        run_to_run();
        base = reload_seen;
        sif.user_sw2_n = 1'b0;
        for (int m = 1; m <= 30; m++) begin
            step();
            if (m == 6) chk("short_rst_sys6", 64'(sif.rst_sys), 64'd0);
            if (m == 7) begin
                chk("short_rst_sys7", 64'(sif.rst_sys), 64'd1);
                chk("short_ft601_7", 64'(sif.ft601_rst_n), 64'd0);
            end
            if (m == 20) chk("short_uptime_hold", sif.uptime, 64'd0);
        end
        sif.user_sw2_n = 1'b1;
        release_checks("short");
        chk("short_no_reload", 64'(reload_seen - base), 64'd0);

        // long SW2 press
        run_to_run();
        base = reload_seen;
        sif.user_sw2_n = 1'b0;
        for (int m = 1; m <= 200; m++) begin
            step();
            if (m == 106) chk("long_reload106", 64'(sif.rst_cfg_reload), 64'd0);
            if (m == 107) chk("long_reload107", 64'(sif.rst_cfg_reload), 64'd1);
            if (m == 108) chk("long_reload108", 64'(sif.rst_cfg_reload), 64'd0);
            if (m == 150) chk("long_rst_sys150", 64'(sif.rst_sys), 64'd1);
        end
        sif.user_sw2_n = 1'b1;
        release_checks("long");
        chk("long_one_pulse", 64'(reload_seen - base), 64'd1);

        // bounce on SW2 must never be accepted
        run_to_run();
        hi_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            sif.user_sw2_n = ((k >> 1) & 1) ? 1'b1 : 1'b0;
            step();
            if (sif.rst_sys !== 1'b0) hi_cnt++;
        end
        sif.user_sw2_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sif.rst_sys !== 1'b0) hi_cnt++;
        end
        chk("bounce_rst_sys_high_cycles", 64'(hi_cnt), 64'd0);
        chk("bounce_uptime", sif.uptime, 64'd52);

        // async rst while running acts before the next edge
        #2 rst = 1'b1;
        #1;
        chk("async_run_rst_sys", 64'(sif.rst_sys), 64'd1);
        chk("async_run_uptime", sif.uptime, 64'd0);
        chk("async_run_ft601", 64'(sif.ft601_rst_n), 64'd0);
        step();

        // async rst mid-HOLD at hold count 50
        run_to_run();
        base = reload_seen;
        sif.user_sw2_n = 1'b0;
        repeat (57) step();
        chk("hold50_rst_sys", 64'(sif.rst_sys), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_hold_rst_sys", 64'(sif.rst_sys), 64'd1);
        chk("async_hold_reload", 64'(sif.rst_cfg_reload), 64'd0);
        chk("async_hold_led", 64'(sif.led_invert), 64'd0);
        chk("async_hold_uptime", sif.uptime, 64'd0);
        repeat (120) step();
        sif.user_sw2_n = 1'b1;
        chk("async_hold_no_reload", 64'(reload_seen - base), 64'd0);
        step();
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (n == 7) chk("repor_rst_sys7", 64'(sif.rst_sys), 64'd1);
            if (n == 8) chk("repor_rst_sys8", 64'(sif.rst_sys), 64'd0);
            if (n == 9) chk("repor_uptime9", sif.uptime, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
